// File: rtl/seg7_pkg.sv
// Glyph constants and nibble decode shared by the 7-segment scan driver.
// Define SEG7_HEX_GLYPH_EN to render nibbles 10..15 as hex letters; otherwise they show blank.
package seg7_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] GLYPH_0     = 7'b0111111;
    localparam logic [6:0] GLYPH_1     = 7'b0000110;
    localparam logic [6:0] GLYPH_2     = 7'b1011011;
    localparam logic [6:0] GLYPH_3     = 7'b1001111;
    localparam logic [6:0] GLYPH_4     = 7'b1100110;
    localparam logic [6:0] GLYPH_5     = 7'b1101101;
    localparam logic [6:0] GLYPH_6     = 7'b1111101;
    localparam logic [6:0] GLYPH_7     = 7'b0000111;
    localparam logic [6:0] GLYPH_8     = 7'b1111111;
    localparam logic [6:0] GLYPH_9     = 7'b1100111;
    localparam logic [6:0] GLYPH_A     = 7'b1110111;
    localparam logic [6:0] GLYPH_B     = 7'b1111100;
    localparam logic [6:0] GLYPH_C     = 7'b0111001;
    localparam logic [6:0] GLYPH_D     = 7'b1011110;
    localparam logic [6:0] GLYPH_E     = 7'b1111001;
    localparam logic [6:0] GLYPH_F     = 7'b1110001;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
    localparam logic [6:0] GLYPH_ALL   = 7'b1111111;

`ifdef SEG7_HEX_GLYPH_EN
    localparam bit HEX_GLYPHS = 1'b1;
`else
    localparam bit HEX_GLYPHS = 1'b0;
`endif

    // Letters stay referenced in both builds; the flag alone decides whether they reach the pins.
    function automatic logic [6:0] seg7_glyph(input digit_t nibble);
        logic [6:0] glyph;
        glyph = GLYPH_BLANK;
        case (nibble)
            4'h0:    glyph = GLYPH_0;
            4'h1:    glyph = GLYPH_1;
            4'h2:    glyph = GLYPH_2;
            4'h3:    glyph = GLYPH_3;
            4'h4:    glyph = GLYPH_4;
            4'h5:    glyph = GLYPH_5;
            4'h6:    glyph = GLYPH_6;
            4'h7:    glyph = GLYPH_7;
            4'h8:    glyph = GLYPH_8;
            4'h9:    glyph = GLYPH_9;
            4'hA:    glyph = HEX_GLYPHS ? GLYPH_A : GLYPH_BLANK;
            4'hB:    glyph = HEX_GLYPHS ? GLYPH_B : GLYPH_BLANK;
            4'hC:    glyph = HEX_GLYPHS ? GLYPH_C : GLYPH_BLANK;
            4'hD:    glyph = HEX_GLYPHS ? GLYPH_D : GLYPH_BLANK;
            4'hE:    glyph = HEX_GLYPHS ? GLYPH_E : GLYPH_BLANK;
            4'hF:    glyph = HEX_GLYPHS ? GLYPH_F : GLYPH_BLANK;
            default: glyph = GLYPH_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational per-digit segment pattern: blank-all, lamp test, leading-zero blank, then glyph.
// Hex letters for nibbles 10..15 depend on SEG7_HEX_GLYPH_EN via seg7_glyph.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  digit_t     nibble_i,
    input  logic       lt_i,
    input  logic       bi_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = seg7_glyph(nibble_i);
        if (bi_i) begin
            seg_o = GLYPH_BLANK;
        end else if (lt_i) begin
            seg_o = GLYPH_ALL;
        end else if (blank_i) begin
            seg_o = GLYPH_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with frame-synchronous data update and ghost blanking.
// Hex glyphs for nibbles 10..15 are enabled with SEG7_HEX_GLYPH_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int GHOST_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load,
    input  logic                    lt,
    input  logic                    bi,
    input  logic                    rbi_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] GHOST_END = PRE_W'(GHOST_CYCLES);

    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic                    pending_q, pending_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    frameEnd;
    logic                    zeroAbove;
    logic [NUM_DIGITS-1:0]   suppress;
    digit_t                  digits [NUM_DIGITS];
    logic [6:0]              decodedSeg;

    assign frameEnd = (presc_q == PRE_LAST) && (idx_q == IDX_LAST);

    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRE_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // A load on the boundary cycle still refreshes the shadow and keeps pending for the next frame.
    always_comb begin
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        if (frameEnd && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = data_in;
            pending_d = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign digits[g] = disp_q[4*g +: 4];
    end

    // Walk from the most significant digit down; a digit blanks only while everything above is zero.
    always_comb begin
        zeroAbove = 1'b1;
        suppress  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeroAbove   = zeroAbove && (digits[i] == 4'h0);
            suppress[i] = rbi_en && (i > 0) && zeroAbove;
        end
    end

    seg7_digit_decode u_decode (
        .nibble_i (digits[idx_q]),
        .lt_i     (lt),
        .bi_i     (bi),
        .blank_i  (suppress[idx_q]),
        .seg_o    (decodedSeg)
    );

    always_comb begin
        seg_d = decodedSeg;
        an_d  = '0;
        if (presc_q >= GHOST_END) begin
            an_d[idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            seg_q     <= '0;
            an_q      <= '0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    // Registers hold logical levels so reset means "off" whatever the board polarity.
    assign seg = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign an  = AN_ACTIVE_LOW  ? ~an_q  : an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed plus randomized bench for seg7_scan_driver against a cycle-arithmetic reference model.
// Hex expectations follow SEG7_HEX_GLYPH_EN exactly like the design build.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int GHOST = 2;
    localparam int FRAME = ND * DIV;

    localparam logic [6:0] G0  = 7'b0111111;
    localparam logic [6:0] G1  = 7'b0000110;
    localparam logic [6:0] G2  = 7'b1011011;
    localparam logic [6:0] G3  = 7'b1001111;
    localparam logic [6:0] G4  = 7'b1100110;
    localparam logic [6:0] GB  = 7'b0000000;
    localparam logic [6:0] GAL = 7'b1111111;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic [15:0] dataIn = '0;
    logic        load   = 1'b0;
    logic        lt     = 1'b0;
    logic        bi     = 1'b0;
    logic        rbiEn  = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks   = 0;
    int failures = 0;

    int          tM      = 0;
    logic [15:0] shadowM = '0;
    logic [15:0] dispM   = '0;
    logic        pendM   = 1'b0;
    logic [6:0]  expSeg  = '0;
    logic [3:0]  expAn   = '0;

    seg7_scan_driver #(
        .NUM_DIGITS     (ND),
        .CLK_DIV        (DIV),
        .GHOST_CYCLES   (GHOST),
        .SEG_ACTIVE_LOW (1'b0),
        .AN_ACTIVE_LOW  (1'b0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (dataIn),
        .load    (load),
        .lt      (lt),
        .bi      (bi),
        .rbi_en  (rbiEn),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    // Glyph table written straight from the decode list.
    function automatic logic [6:0] refGlyph(input int n);
        case (n)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1100111;
`ifdef SEG7_HEX_GLYPH_EN
            10: return 7'b1110111;
            11: return 7'b1111100;
            12: return 7'b0111001;
            13: return 7'b1011110;
            14: return 7'b1111001;
            15: return 7'b1110001;
`endif
            default: return 7'b0000000;
        endcase
    endfunction

    // A digit is a leading zero exactly when the value shifted down to it is zero.
    function automatic logic [6:0] modelSeg(input logic [15:0] val, input int idx,
                                            input logic ltV, input logic biV, input logic rbiV);
        if (biV) return 7'b0000000;
        if (ltV) return 7'b1111111;
        if (rbiV && idx > 0 && (val >> (4 * idx)) == 16'h0) return 7'b0000000;
        return refGlyph(int'((val >> (4 * idx)) & 16'hF));
    endfunction

    // Reference model: tM counts clocks since reset release; slot and digit come from division.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tM      <= 0;
            shadowM <= '0;
            dispM   <= '0;
            pendM   <= 1'b0;
            expSeg  <= '0;
            expAn   <= '0;
        end else begin
            expAn  <= ((tM % DIV) < GHOST) ? 4'b0000 : 4'(1 << ((tM / DIV) % ND));
            expSeg <= modelSeg(dispM, (tM / DIV) % ND, lt, bi, rbiEn);
            if ((tM % FRAME) == FRAME - 1 && pendM) dispM <= shadowM;
            if (load) begin
                shadowM <= dataIn;
                pendM   <= 1'b1;
            end else if ((tM % FRAME) == FRAME - 1) begin
                pendM <= 1'b0;
            end
            tM <= tM + 1;
        end
    end

    task automatic applyStimulus(input logic ldV, input logic [15:0] dV,
                                 input logic ltV, input logic biV, input logic rbiV);
        load   = ldV;
        dataIn = dV;
        lt     = ltV;
        bi     = biV;
        rbiEn  = rbiV;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (seg === expSeg) else begin
            failures++;
            $error("[TB] FAIL %s seg observed=%b expected=%b", tag, seg, expSeg);
        end
        checks++;
        assert (an === expAn) else begin
            failures++;
            $error("[TB] FAIL %s an observed=%b expected=%b", tag, an, expAn);
        end
    endtask

    task automatic checkConst(input string tag, input logic [6:0] segE, input logic [3:0] anE);
        checks++;
        assert (seg === segE) else begin
            failures++;
            $error("[TB] FAIL %s seg observed=%b expected=%b", tag, seg, segE);
        end
        checks++;
        assert (an === anE) else begin
            failures++;
            $error("[TB] FAIL %s an observed=%b expected=%b", tag, an, anE);
        end
    endtask

    // Advance until the outputs reflect (slot, prescaler), model-checking every cycle on the way.
    task automatic waitPhase(input int slot, input int presc);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            checkOutput("scan_model");
            if (tM > 0 && ((tM - 1) % DIV) == presc && (((tM - 1) / DIV) % ND) == slot) found = 1'b1;
        end
        checks++;
        assert (found) else begin
            failures++;
            $error("[TB] FAIL wait_phase slot=%0d presc=%0d observed=timeout expected=reached", slot, presc);
        end
    endtask

    task automatic checkFrame(input string tag, input logic [27:0] segs);
        waitPhase(0, 0);
        checkConst({tag, "_ghost"}, segs[6:0], 4'b0000);
        for (int s = 0; s < ND; s++) begin
            waitPhase(s, GHOST);
            checkConst($sformatf("%s_d%0d", tag, s), segs[7*s +: 7], 4'(1 << s));
        end
    endtask

    task automatic loadValue(input logic [15:0] v);
        @(negedge clk);
        applyStimulus(1'b1, v, lt, bi, rbiEn);
        @(negedge clk);
        applyStimulus(1'b0, v, lt, bi, rbiEn);
    endtask

    task automatic loadAndSettle(input logic [15:0] v);
        loadValue(v);
        waitPhase(0, 0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        #1 rst_n = 1'b0;
        #2 checkConst("reset", GB, 4'b0000);
        checkOutput("reset_model");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        checkFrame("preload", {G0, G0, G0, G0});
        waitPhase(3, 1);
        checkConst("ghost_d3", G0, 4'b0000);

        loadAndSettle(16'h1234);
        checkFrame("val1234", {G1, G2, G3, G4});

        applyStimulus(1'b0, dataIn, 1'b0, 1'b0, 1'b1);
        loadAndSettle(16'h0040);
        checkFrame("rbi_on", {GB, GB, G4, G0});
        applyStimulus(1'b0, dataIn, 1'b0, 1'b0, 1'b0);
        checkFrame("rbi_off", {G0, G0, G4, G0});

        applyStimulus(1'b0, dataIn, 1'b0, 1'b0, 1'b1);
        loadAndSettle(16'h0000);
        checkFrame("all_zero", {GB, GB, GB, G0});

        applyStimulus(1'b0, dataIn, 1'b1, 1'b0, 1'b1);
        checkFrame("lamp_test", {GAL, GAL, GAL, GAL});
        applyStimulus(1'b0, dataIn, 1'b1, 1'b1, 1'b1);
        checkFrame("lt_bi", {GB, GB, GB, GB});
        applyStimulus(1'b0, dataIn, 1'b0, 1'b0, 1'b1);

        waitPhase(1, 3);
        loadValue(16'h1111);
        loadValue(16'h2222);
        checkFrame("last_wins", {G2, G2, G2, G2});

        waitPhase(3, DIV - 2);
        applyStimulus(1'b1, 16'h3333, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("boundary_load_model");
        applyStimulus(1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
        checkFrame("boundary_old", {G2, G2, G2, G2});
        checkFrame("boundary_new", {G3, G3, G3, G3});

        loadAndSettle(16'h00AF);
`ifdef SEG7_HEX_GLYPH_EN
        checkFrame("hex_rbi", {GB, GB, 7'b1110111, 7'b1110001});
        applyStimulus(1'b0, dataIn, 1'b0, 1'b0, 1'b0);
        checkFrame("hex_norbi", {G0, G0, 7'b1110111, 7'b1110001});
`else
        checkFrame("hex_rbi", {GB, GB, GB, GB});
        applyStimulus(1'b0, dataIn, 1'b0, 1'b0, 1'b0);
        checkFrame("hex_norbi", {G0, G0, GB, GB});
`endif

        waitPhase(2, 4);
        #2 rst_n = 1'b0;
        #1 checkConst("async_reset", GB, 4'b0000);
        checkOutput("async_reset_model");
        @(negedge clk);
        rst_n = 1'b1;
        checkFrame("post_reset", {G0, G0, G0, G0});

        for (int c = 0; c < 600; c++) begin
            logic [15:0] d;
            @(negedge clk);
            checkOutput("random");
            d = '0;
            for (int n = 0; n < ND; n++) begin
                if ($urandom_range(0, 2) == 0) d[4*n +: 4] = 4'($urandom_range(0, 15));
            end
            applyStimulus($urandom_range(0, 7) == 0, d,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 15) == 0,
                          ($urandom_range(0, 15) == 0) ? ~rbiEn : rbiEn);
        end
        @(negedge clk);
        checkOutput("random_last");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
